// File: rtl/vscale_dmem_bridge_pkg.sv
// vscale_dmem_bridge_pkg: shared widths, size codes and FSM state encoding for the dmem bridge
package vscale_dmem_bridge_pkg;

    localparam int XPR_LEN = 32;
    localparam int DMEM_BUS_WSTRB_WIDTH = 4;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/vscale_dmem_check.sv
// vscale_dmem_check: combinational legality check and byte-strobe generation for a DX request
module vscale_dmem_check
    import vscale_dmem_bridge_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
    parameter logic [31:0] DMEM_BYTES = 32'h0001_0000
) (
    input  logic [XPR_LEN-1:0]              addr,
    input  logic [2:0]                      size,
    output logic                            illegal,
    output logic [DMEM_BUS_WSTRB_WIDTH-1:0] wstrb
);

    logic [2:0]  nbytes;
    logic [32:0] last;
    logic [32:0] limit;
    logic        misalign;

    // 33-bit end-of-access math so an access wrapping past 2^32 is flagged
    always_comb begin
        nbytes   = size == SIZE_BYTE ? 3'd1 : size == SIZE_HALF ? 3'd2 : 3'd4;
        last     = {1'b0, addr} + {30'd0, nbytes} - 33'd1;
        limit    = {1'b0, DMEM_BASE} + {1'b0, DMEM_BYTES};
        misalign = (size == SIZE_HALF && addr[0]) || (size == SIZE_WORD && addr[1:0] != 2'b00);
        illegal  = size > SIZE_WORD || misalign || addr < DMEM_BASE || last >= limit;
        wstrb    = size == SIZE_BYTE ? 4'b0001 << addr[1:0] :
                   size == SIZE_HALF ? 4'b0011 << addr[1:0] : 4'b1111;
    end

endmodule

// File: rtl/vscale_dmem_bridge.sv
// vscale_dmem_bridge: pairs DX requests with delayed store data and runs one valid/ready bus transaction at a time
module vscale_dmem_bridge
    import vscale_dmem_bridge_pkg::*;
#(
    parameter logic [31:0] DMEM_BASE      = 32'h0000_0000,
    parameter logic [31:0] DMEM_BYTES     = 32'h0001_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            dmem_en,
    input  logic                            dmem_wen,
    input  logic [2:0]                      dmem_size,
    input  logic [XPR_LEN-1:0]              dmem_addr,
    input  logic [XPR_LEN-1:0]              dmem_wdata_delayed,
    output logic [XPR_LEN-1:0]              dmem_rdata,
    output logic                            dmem_wait,
    output logic                            dmem_badmem_e,
    output logic                            bus_req_valid,
    input  logic                            bus_req_ready,
    output logic                            bus_req_wen,
    output logic [XPR_LEN-1:0]              bus_req_addr,
    output logic [XPR_LEN-1:0]              bus_req_wdata,
    output logic [DMEM_BUS_WSTRB_WIDTH-1:0] bus_req_wstrb,
    input  logic                            bus_resp_valid,
    input  logic [XPR_LEN-1:0]              bus_resp_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                          state, state_n;
    logic [XPR_LEN-3:0]              addr_q;
    logic                            wen_q;
    logic [DMEM_BUS_WSTRB_WIDTH-1:0] wstrb_q;
    logic [XPR_LEN-1:0]              wdata_q;
    logic [XPR_LEN-1:0]              rdata_q;
    logic [7:0]                      cnt;
    logic                            first_q;
    logic                            illegal;
    logic [DMEM_BUS_WSTRB_WIDTH-1:0] wstrb_c;
    logic                            timeout;
    logic                            done;
    logic                            accept;

    vscale_dmem_check #(
        .DMEM_BASE  (DMEM_BASE),
        .DMEM_BYTES (DMEM_BYTES)
    ) u_check (
        .addr    (dmem_addr),
        .size    (dmem_size),
        .illegal (illegal),
        .wstrb   (wstrb_c)
    );

    // next state and outputs; the last counted RESP cycle wins over a simultaneous response
    always_comb begin
        timeout       = state == S_RESP && cnt == TO_LAST;
        done          = state == S_RESP && bus_resp_valid && !timeout;
        accept        = state == S_IDLE || state == S_ERR || done;
        state_n       = accept ? (!dmem_en ? S_IDLE : illegal ? S_ERR : S_REQ) :
                        (state == S_REQ && bus_req_ready) ? S_RESP :
                        timeout ? S_ERR : state;
        bus_req_valid = state == S_REQ;
        bus_req_wen   = bus_req_valid && wen_q;
        bus_req_addr  = {addr_q, 2'b00};
        bus_req_wdata = first_q ? dmem_wdata_delayed : wdata_q;
        bus_req_wstrb = bus_req_wen ? wstrb_q : '0;
        dmem_wait     = state == S_REQ || (state == S_RESP && !done);
        dmem_badmem_e = state == S_ERR;
        dmem_rdata    = done ? bus_resp_rdata : rdata_q;
    end

    // state, captured request, held store data, last load word and RESP cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= 8'd0;
            first_q <= 1'b0;
        end else begin
            state   <= state_n;
            first_q <= state_n == S_REQ && state != S_REQ;
            if (accept && dmem_en) begin
                addr_q  <= dmem_addr[XPR_LEN-1:2];
                wen_q   <= dmem_wen;
                wstrb_q <= wstrb_c;
            end
            if (first_q) wdata_q <= dmem_wdata_delayed;
            if (done) rdata_q <= bus_resp_rdata;
            cnt <= state == S_RESP ? cnt + 8'd1 : 8'd0;
        end
    end

endmodule
